// File: rtl/alu_disp_pkg.sv
// alu_disp_pkg: opcode encodings, flag bit positions and the hex 7-segment font
// shared by the ALU and the display scanner.
package alu_disp_pkg;

    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;

    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segment pattern abcdefg (a in the MSB), active-low.
    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/alu_disp_seg7_scan.sv
// seg7_scan: free-running refresh counter, digit mux and font lookup for a
// 4-digit multiplexed display; anodes and cathodes leave the block registered.
// Build option: DISP_BLANK_LZ_EN blanks digits above the highest nonzero nibble.
module seg7_scan
    import alu_disp_pkg::*;
#(
    parameter int unsigned SCAN_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    output logic [1:7]  cath,
    output logic [3:0]  an
);

    logic [SCAN_BITS-1:0] cnt_q, cnt_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           cath_q, cath_d;
    logic [1:0]           sel;
    logic [3:0]           nibble;
    logic                 blank;

    always_comb begin
        sel    = cnt_q[SCAN_BITS-1 -: 2];
        nibble = value[{sel, 2'b00} +: 4];
        blank  = 1'b0;
`ifdef DISP_BLANK_LZ_EN
        // Digit 0 is never blanked so that a zero value still shows "0".
        blank  = (sel != 2'd0) && ((value >> {sel, 2'b00}) == '0);
`endif
        cnt_d  = cnt_q + SCAN_BITS'(1);
        an_d   = ~(4'b0001 << sel);
        cath_d = blank ? SEG_BLANK : seg_font(nibble);
        if (reset) begin
            cnt_d  = '0;
            an_d   = '1;
            cath_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        an_q   <= an_d;
        cath_q <= cath_d;
    end

    assign an   = an_q;
    assign cath = cath_q;

endmodule

// File: rtl/alu_disp_core.sv
// alu_disp_core: combinational ALU with {C,F,Z,N} flags and a scanned 4-digit
// hex display of the result. Build option: DISP_BLANK_LZ_EN (leading-zero blanking).
module alu_disp_core
    import alu_disp_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SCAN_BITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic [WIDTH-1:0] rout,
    output logic [3:0]       flags,
    output logic [1:7]       cath,
    output logic [3:0]       an
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             c_flag;
    logic             f_flag;
    logic             op_valid;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        res      = '0;
        c_flag   = 1'b0;
        f_flag   = 1'b0;
        op_valid = 1'b1;
        case (aluc)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_ADD: begin
                res    = sum[WIDTH-1:0];
                c_flag = sum[WIDTH];
                f_flag = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                // The extra MSB of the zero-extended difference is the borrow.
                res    = diff[WIDTH-1:0];
                c_flag = diff[WIDTH];
                f_flag = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MOV: res = b;
            default: op_valid = 1'b0;
        endcase

        flags = '0;
        if (op_valid) begin
            flags[FLAG_C] = c_flag;
            flags[FLAG_F] = f_flag;
            flags[FLAG_Z] = (res == '0);
            flags[FLAG_N] = res[WIDTH-1];
        end
    end

    assign rout = res;

    seg7_scan #(
        .SCAN_BITS(SCAN_BITS)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .value (res[15:0]),
        .cath  (cath),
        .an    (an)
    );

endmodule

// File: tb/tb_alu_disp_core.sv
// Scoreboard bench for alu_disp_core: stimulus queues expected ALU and display
// values per cycle; a negedge monitor pops and compares them.
module tb_alu_disp_core;
    import alu_disp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a, b;
    logic [3:0]  aluc;
    logic [15:0] rout;
    logic [3:0]  flags;
    logic [1:7]  cath;
    logic [3:0]  an;

    int unsigned tests = 0;
    int unsigned fails = 0;

    typedef struct packed {
        logic [15:0] rout;
        logic [3:0]  flags;
        logic [3:0]  an;
        logic [6:0]  cath;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] S0  = 7'b0000001;
    localparam logic [6:0] S1  = 7'b1001111;
    localparam logic [6:0] S2  = 7'b0010010;
    localparam logic [6:0] S4  = 7'b1001100;
    localparam logic [6:0] SA  = 7'b0001000;
    localparam logic [6:0] SF  = 7'b0111000;
`ifdef DISP_BLANK_LZ_EN
    localparam logic [6:0] LZ  = BLK;
`else
    localparam logic [6:0] LZ  = S0;
`endif

    alu_disp_core #(
        .WIDTH     (16),
        .SCAN_BITS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .aluc  (aluc),
        .rout  (rout),
        .flags (flags),
        .cath  (cath),
        .an    (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input string what,
                         input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s.%s: got %h, expected %h", nm, what, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, "rout",  rout,       e.rout);
            check(nm, "flags", 16'(flags), 16'(e.flags));
            check(nm, "an",    16'(an),    16'(e.an));
            check(nm, "cath",  16'(cath),  16'(e.cath));
        end
    end

    // Drive inputs just after a rising edge; expectations describe this cycle.
    task automatic step(input string nm, input logic r,
                        input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] op,
                        input logic [15:0] er, input logic [3:0] ef,
                        input logic [3:0] ean, input logic [6:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r;
        a     = ia;
        b     = ib;
        aluc  = op;
        e     = '{rout: er, flags: ef, an: ean, cath: ec};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a     = 16'h0001;
        b     = 16'h0002;
        aluc  = OP_ADD;

        // ALU vectors while reset holds the display blank
        step("add_1_2",     1'b1, 16'h0001, 16'h0002, OP_ADD,  16'h0003, 4'b0000, 4'b1111, BLK);
        step("add_ovf",     1'b1, 16'h7FFF, 16'h0001, OP_ADD,  16'h8000, 4'b0101, 4'b1111, BLK);
        step("add_carry",   1'b1, 16'hFFFF, 16'h0001, OP_ADD,  16'h0000, 4'b1010, 4'b1111, BLK);
        step("sub_3_5",     1'b1, 16'h0003, 16'h0005, OP_SUB,  16'hFFFE, 4'b1001, 4'b1111, BLK);
        step("or",          1'b1, 16'h0003, 16'h0004, OP_OR,   16'h0007, 4'b0000, 4'b1111, BLK);
        step("not",         1'b1, 16'h0007, 16'h0000, OP_NOT,  16'hFFF8, 4'b0001, 4'b1111, BLK);
        step("xor",         1'b1, 16'hFFF8, 16'h0007, OP_XOR,  16'hFFFF, 4'b0001, 4'b1111, BLK);
        step("bad_op",      1'b1, 16'h1234, 16'h5678, 4'b1111, 16'h0000, 4'b0000, 4'b1111, BLK);
        step("and",         1'b1, 16'hF0F0, 16'h0FF0, OP_AND,  16'h00F0, 4'b0000, 4'b1111, BLK);
        step("cmp_eq",      1'b1, 16'h0005, 16'h0005, OP_CMP,  16'h0000, 4'b0010, 4'b1111, BLK);
        step("sub_ovf",     1'b1, 16'h8000, 16'h0001, OP_SUB,  16'h7FFF, 4'b0100, 4'b1111, BLK);
        step("mov",         1'b1, 16'h0000, 16'h8000, OP_MOV,  16'h8000, 4'b0001, 4'b1111, BLK);

        // Release reset showing 0x12AF; scan with wrap-around
        step("rel",         1'b0, 16'h0000, 16'h12AF, OP_MOV,  16'h12AF, 4'b0000, 4'b1111, BLK);
        step("scan_d0",     1'b0, 16'h0000, 16'h12AF, OP_MOV,  16'h12AF, 4'b0000, 4'b1110, SF);
        step("scan_d1",     1'b0, 16'h0000, 16'h12AF, OP_MOV,  16'h12AF, 4'b0000, 4'b1101, SA);
        step("scan_d2",     1'b0, 16'h0000, 16'h12AF, OP_MOV,  16'h12AF, 4'b0000, 4'b1011, S2);
        step("scan_d3",     1'b0, 16'h0000, 16'h12AF, OP_MOV,  16'h12AF, 4'b0000, 4'b0111, S1);
        step("wrap_d0",     1'b0, 16'h0000, 16'h12AF, OP_MOV,  16'h12AF, 4'b0000, 4'b1110, SF);
        step("wrap_d1",     1'b0, 16'h0000, 16'h12AF, OP_MOV,  16'h12AF, 4'b0000, 4'b1101, SA);

        // Reset asserted during digit 2, then released
        step("mid_rst_d2",  1'b1, 16'h0000, 16'h12AF, OP_MOV,  16'h12AF, 4'b0000, 4'b1011, S2);
        step("mid_rst_blk", 1'b0, 16'h0000, 16'h12AF, OP_MOV,  16'h12AF, 4'b0000, 4'b1111, BLK);
        step("restart_d0",  1'b0, 16'h0000, 16'h12AF, OP_MOV,  16'h12AF, 4'b0000, 4'b1110, SF);
        step("restart_d1",  1'b0, 16'h0000, 16'h12AF, OP_MOV,  16'h12AF, 4'b0000, 4'b1101, SA);

        // Switch to 0x0040: display follows one clock later
        step("chg_d2_old",  1'b0, 16'h0000, 16'h0040, OP_MOV,  16'h0040, 4'b0000, 4'b1011, S2);
        step("lz_d3",       1'b0, 16'h0000, 16'h0040, OP_MOV,  16'h0040, 4'b0000, 4'b0111, LZ);
        step("lz_d0",       1'b0, 16'h0000, 16'h0040, OP_MOV,  16'h0040, 4'b0000, 4'b1110, S0);
        step("lz_d1",       1'b0, 16'h0000, 16'h0040, OP_MOV,  16'h0040, 4'b0000, 4'b1101, S4);
        step("lz_d2",       1'b0, 16'h0000, 16'h0040, OP_MOV,  16'h0040, 4'b0000, 4'b1011, LZ);
        step("zero_prev",   1'b0, 16'h0000, 16'h0000, OP_MOV,  16'h0000, 4'b0010, 4'b0111, LZ);
        step("zero_d0",     1'b0, 16'h0000, 16'h0000, OP_MOV,  16'h0000, 4'b0010, 4'b1110, S0);
        step("zero_d1",     1'b0, 16'h0000, 16'h0000, OP_MOV,  16'h0000, 4'b0010, 4'b1101, LZ);

        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
